bcd_entry_display: RTL and testbench

Parametrised BCD entry and display-sequencing controller for an N-digit signed value on active-low seven-segment digits. It captures digits one key press at a time, ones digit first, from the BCD switches. During entry it shows the digit being entered live and blinking. After the final digit it commits a signed BCD value with a one-cycle strobe, then cycles display pages between the committed value and an externally supplied result (e.g. a subtractor output). It replaces the fixed 3-digit input/mux logic in the board top level and drives one `seven_seg` instance per digit plus one for the sign.

---
 rtl/bcd_entry_display.sv | 207 ++++++++++++++++++++
 tb/tb_bcd_entry_display.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_entry_display.sv
// BCD key-entry and display-page sequencer for an N-digit signed value.
// Drives per-position codes/enables for the seven_seg instances (top nibble = sign).
module bcd_entry_display #(
    parameter  int unsigned DIGITS    = 3,
    parameter  int unsigned BLINK_DIV = 25000000,
    parameter  int unsigned DWELL_DIV = 50000000,
    localparam int unsigned IDX_W     = $clog2(DIGITS),
    localparam int unsigned MAG_W     = 4 * DIGITS,
    localparam int unsigned CODE_W    = 4 * (DIGITS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        digit_in,
    input  logic              sign_in,
    input  logic              enter,
    input  logic              clear,
    input  logic [MAG_W-1:0]  result_bcd,
    input  logic              result_neg,
    output logic [MAG_W-1:0]  value_bcd,
    output logic              value_neg,
    output logic              value_valid,
    output logic              entry_err,
    output logic [IDX_W-1:0]  entry_idx,
    output logic              entering,
    output logic [1:0]        page,
    output logic [CODE_W-1:0] disp_code,
    output logic [DIGITS:0]   disp_en
);

    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned DWELL_W = (DWELL_DIV > 1) ? $clog2(DWELL_DIV) : 1;

    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(DIGITS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_DIV - 1);
    localparam logic [3:0]         CODE_NEG   = 4'hA;
    localparam logic [3:0]         CODE_OFF   = 4'hF;

    typedef enum logic {
        ST_ENTRY = 1'b0,
        ST_SHOW  = 1'b1
    } state_e;

    state_e             state_q,       state_d;
    logic [IDX_W-1:0]   idx_q,         idx_d;
    logic [MAG_W-1:0]   digits_q,      digits_d;
    logic [MAG_W-1:0]   value_bcd_q,   value_bcd_d;
    logic               value_neg_q,   value_neg_d;
    logic               value_valid_q, value_valid_d;
    logic               entry_err_q,   entry_err_d;
    logic [1:0]         page_q,        page_d;
    logic [DWELL_W-1:0] dwell_q,       dwell_d;
    logic [BLINK_W-1:0] blink_cnt_q,   blink_cnt_d;
    logic               blink_q,       blink_d;
    logic               enter_q,       enter_d;

    logic               press_c;
    logic               digit_ok_c;
    logic [MAG_W-1:0]   captured_c;

    assign press_c    = enter & ~enter_q;
    assign digit_ok_c = (digit_in <= 4'd9);

    // Captured digits with the live switch value dropped into the current slot.
    always_comb begin : capture_merge
        captured_c = digits_q;
        for (int unsigned p = 0; p < DIGITS; p++) begin
            if (idx_q == IDX_W'(p)) begin
                captured_c[4*p +: 4] = digit_in;
            end
        end
    end

    always_comb begin : next_state
        state_d       = state_q;
        idx_d         = idx_q;
        digits_d      = digits_q;
        value_bcd_d   = value_bcd_q;
        value_neg_d   = value_neg_q;
        value_valid_d = 1'b0;
        entry_err_d   = 1'b0;
        page_d        = page_q;
        dwell_d       = dwell_q;
        enter_d       = enter;

        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
            blink_d     = blink_q;
        end

        case (state_q)
            ST_ENTRY: begin
                page_d  = 2'd0;
                dwell_d = '0;
                if (clear) begin
                    idx_d    = '0;
                    digits_d = '0;
                end else if (press_c && digit_ok_c) begin
                    digits_d    = captured_c;
                    blink_cnt_d = '0;
                    blink_d     = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        // Commit; an all-zero magnitude never carries a minus sign.
                        value_bcd_d   = captured_c;
                        value_neg_d   = sign_in && (captured_c != '0);
                        value_valid_d = 1'b1;
                        state_d       = ST_SHOW;
                        idx_d         = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (press_c) begin
                    entry_err_d = 1'b1;
                end
            end
            ST_SHOW: begin
                blink_cnt_d = '0;
                blink_d     = 1'b1;
                if (press_c) begin
                    state_d  = ST_ENTRY;
                    idx_d    = '0;
                    digits_d = '0;
                    page_d   = 2'd0;
                    dwell_d  = '0;
                end else if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    page_d  = page_q + 2'd1;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_ENTRY;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : state_regs
        if (!rst_n) begin
            state_q       <= ST_ENTRY;
            idx_q         <= '0;
            digits_q      <= '0;
            value_bcd_q   <= '0;
            value_neg_q   <= 1'b0;
            value_valid_q <= 1'b0;
            entry_err_q   <= 1'b0;
            page_q        <= 2'd0;
            dwell_q       <= '0;
            blink_cnt_q   <= '0;
            blink_q       <= 1'b1;
            enter_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            digits_q      <= digits_d;
            value_bcd_q   <= value_bcd_d;
            value_neg_q   <= value_neg_d;
            value_valid_q <= value_valid_d;
            entry_err_q   <= entry_err_d;
            page_q        <= page_d;
            dwell_q       <= dwell_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_q       <= blink_d;
            enter_q       <= enter_d;
        end
    end

    // Per-position display codes; blanks default to OFF with enable high.
    always_comb begin : display
        disp_code = {CODE_W{1'b1}};
        disp_en   = '1;
        for (int unsigned p = 0; p < DIGITS; p++) begin
            if (state_q == ST_SHOW) begin
                if (page_q == 2'd0) begin
                    disp_code[4*p +: 4] = value_bcd_q[4*p +: 4];
                end else if (page_q == 2'd2) begin
                    disp_code[4*p +: 4] = result_bcd[4*p +: 4];
                end
            end else if (IDX_W'(p) < idx_q) begin
                disp_code[4*p +: 4] = digits_q[4*p +: 4];
            end else if (IDX_W'(p) == idx_q) begin
                disp_code[4*p +: 4] = digit_ok_c ? digit_in : CODE_OFF;
                disp_en[p]          = blink_q;
            end
        end
        if (state_q == ST_SHOW) begin
            if ((page_q == 2'd0 && value_neg_q) || (page_q == 2'd2 && result_neg)) begin
                disp_code[CODE_W-1 -: 4] = CODE_NEG;
            end
        end else if (sign_in) begin
            disp_code[CODE_W-1 -: 4] = CODE_NEG;
        end
    end

    assign value_bcd   = value_bcd_q;
    assign value_neg   = value_neg_q;
    assign value_valid = value_valid_q;
    assign entry_err   = entry_err_q;
    assign entry_idx   = idx_q;
    assign entering    = (state_q == ST_ENTRY);
    assign page        = page_q;

endmodule

// File: tb/tb_bcd_entry_display.sv
// Randomised bench for bcd_entry_display against an integer-level behavioural model,
// plus directed scenarios with hand-computed expectations.
module tb_bcd_entry_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  digit_in;
    logic        sign_in;
    logic        enter;
    logic        clear;
    logic [11:0] result_bcd;
    logic        result_neg;
    logic [11:0] value_bcd;
    logic        value_neg;
    logic        value_valid;
    logic        entry_err;
    logic [1:0]  entry_idx;
    logic        entering;
    logic [1:0]  page;
    logic [15:0] disp_code;
    logic [3:0]  disp_en;

    int checks   = 0;
    int failures = 0;

    bcd_entry_display #(
        .DIGITS   (3),
        .BLINK_DIV(4),
        .DWELL_DIV(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digit_in   (digit_in),
        .sign_in    (sign_in),
        .enter      (enter),
        .clear      (clear),
        .result_bcd (result_bcd),
        .result_neg (result_neg),
        .value_bcd  (value_bcd),
        .value_neg  (value_neg),
        .value_valid(value_valid),
        .entry_err  (entry_err),
        .entry_idx  (entry_idx),
        .entering   (entering),
        .page       (page),
        .disp_code  (disp_code),
        .disp_en    (disp_en)
    );

    always #5 clk = ~clk;

    // Behavioural model: decimal integers, elapsed-cycle counts.
    bit m_show       = 1'b0;
    int m_idx        = 0;
    int m_ent [3]    = '{0, 0, 0};
    int m_value      = 0;
    bit m_neg        = 1'b0;
    bit m_valid      = 1'b0;
    bit m_err        = 1'b0;
    int m_since      = 0;
    int m_show_cyc   = 0;
    bit m_prev_enter = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_show = 1'b0; m_idx = 0; m_ent = '{0, 0, 0}; m_value = 0; m_neg = 1'b0;
            m_valid = 1'b0; m_err = 1'b0; m_since = 0; m_show_cyc = 0; m_prev_enter = 1'b1;
        end else begin
            bit pressed;
            bit restart;
            pressed      = enter && !m_prev_enter;
            m_prev_enter = enter;
            m_valid      = 1'b0;
            m_err        = 1'b0;
            restart      = 1'b0;
            if (!m_show) begin
                if (clear) begin
                    m_idx = 0;
                end else if (pressed) begin
                    if (int'(digit_in) <= 9) begin
                        m_ent[m_idx] = int'(digit_in);
                        restart = 1'b1;
                        if (m_idx == 2) begin
                            m_value    = m_ent[0] + 10 * m_ent[1] + 100 * m_ent[2];
                            m_neg      = sign_in && (m_value != 0);
                            m_valid    = 1'b1;
                            m_show     = 1'b1;
                            m_show_cyc = 0;
                            m_idx      = 0;
                        end else begin
                            m_idx = m_idx + 1;
                        end
                    end else begin
                        m_err = 1'b1;
                    end
                end
                m_since = restart ? 0 : m_since + 1;
            end else if (pressed) begin
                m_show  = 1'b0;
                m_idx   = 0;
                m_since = 0;
            end else begin
                m_show_cyc = m_show_cyc + 1;
            end
        end
    end

    function automatic logic [11:0] to_bcd(input int v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int model_page();
        return m_show ? (m_show_cyc / 8) % 4 : 0;
    endfunction

    task automatic model_disp(output logic [15:0] code, output logic [3:0] en);
        int  pg;
        int  div;
        bit  neg;
        pg   = model_page();
        code = 16'hFFFF;
        en   = 4'hF;
        for (int p = 0; p < 3; p++) begin
            logic [3:0] d;
            d   = 4'hF;
            div = (p == 0) ? 1 : ((p == 1) ? 10 : 100);
            if (m_show) begin
                if (pg == 0) d = 4'((m_value / div) % 10);
                else if (pg == 2) d = result_bcd[4*p +: 4];
            end else if (p < m_idx) begin
                d = 4'(m_ent[p]);
            end else if (p == m_idx) begin
                d     = (int'(digit_in) > 9) ? 4'hF : digit_in;
                en[p] = ((m_since / 4) % 2) == 0;
            end
            code[4*p +: 4] = d;
        end
        neg = m_show ? ((pg == 0 && m_neg) || (pg == 2 && result_neg)) : sign_in;
        code[15:12] = neg ? 4'hA : 4'hF;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    initial begin
        logic [15:0] e_code;
        logic [3:0]  e_en;
        forever begin
            @(posedge clk);
            #2;
            model_disp(e_code, e_en);
            chk("value_bcd",   32'(value_bcd),   32'(to_bcd(m_value)));
            chk("value_neg",   32'(value_neg),   32'(m_neg));
            chk("value_valid", 32'(value_valid), 32'(m_valid));
            chk("entry_err",   32'(entry_err),   32'(m_err));
            chk("entry_idx",   32'(entry_idx),   32'(m_idx));
            chk("entering",    32'(entering),    32'(!m_show));
            chk("page",        32'(page),        32'(model_page()));
            chk("disp_code",   32'(disp_code),   32'(e_code));
            chk("disp_en",     32'(disp_en),     32'(e_en));
        end
    end

    task automatic press(input logic [3:0] d, input logic s);
        @(negedge clk);
        digit_in = d;
        sign_in  = s;
        enter    = 1'b1;
        @(negedge clk);
        enter = 1'b0;
    endtask

    initial begin
        bit quiet;
        int len;
        rst_n      = 1'b0;
        enter      = 1'b0;
        clear      = 1'b0;
        digit_in   = 4'd0;
        sign_in    = 1'b0;
        result_bcd = 12'h048;
        result_neg = 1'b1;
        #12;
        chk("lit_rst_code",  32'(disp_code),   32'h0000FFF0);
        chk("lit_rst_en",    32'(disp_en),     32'hF);
        chk("lit_rst_idx",   32'(entry_idx),   32'd0);
        chk("lit_rst_valid", 32'(value_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic entry 5,2,1 -> 125
        press(4'd5, 1'b0);
        press(4'd2, 1'b0);
        press(4'd1, 1'b0);
        #1;
        chk("lit_basic_valid", 32'(value_valid), 32'd1);
        chk("lit_basic_value", 32'(value_bcd),   32'h125);
        chk("lit_basic_show",  32'(entering),    32'd0);
        chk("lit_basic_code",  32'(disp_code),   32'h0000F125);

        // Result page with negative result 048
        for (int i = 0; i < 40 && page != 2'd2; i++) @(negedge clk);
        #1;
        chk("lit_page2_reached", 32'(page),      32'd2);
        chk("lit_page2_code",    32'(disp_code), 32'h0000A048);

        // Negative zero
        press(4'd0, 1'b0);
        press(4'd0, 1'b1);
        press(4'd0, 1'b1);
        press(4'd0, 1'b1);
        #1;
        chk("lit_negzero_valid", 32'(value_valid), 32'd1);
        chk("lit_negzero_neg",   32'(value_neg),   32'd0);

        // Invalid digit at idx 1
        press(4'd0, 1'b0);
        press(4'd3, 1'b0);
        press(4'hC, 1'b0);
        #1;
        chk("lit_err_pulse", 32'(entry_err), 32'd1);
        chk("lit_err_idx",   32'(entry_idx), 32'd1);
        press(4'd7, 1'b0);
        #1;
        chk("lit_after_err_pos1", 32'(disp_code[7:4]), 32'd7);

        // Clear together with a press at idx 2
        @(negedge clk);
        digit_in = 4'd4;
        enter    = 1'b1;
        clear    = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        clear = 1'b0;
        #1;
        chk("lit_clear_idx",   32'(entry_idx),   32'd0);
        chk("lit_clear_valid", 32'(value_valid), 32'd0);
        chk("lit_clear_err",   32'(entry_err),   32'd0);

        // Blink restarts on capture
        press(4'd6, 1'b0);
        #1;
        chk("lit_blink_on", 32'(disp_en[1]), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("lit_blink_off", 32'(disp_en[1]), 32'd0);

        // Asynchronous reset mid-entry, key held through release
        press(4'd8, 1'b0);
        @(posedge clk);
        #3;
        enter = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("lit_async_idx",  32'(entry_idx), 32'd0);
        chk("lit_async_code", 32'(disp_code), 32'h0000FFF8);
        chk("lit_async_en",   32'(disp_en),   32'hF);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        enter = 1'b0;

        // Randomised traffic with idle stretches to let pages roll over
        for (int seg = 0; seg < 150; seg++) begin
            quiet = ($urandom_range(0, 3) == 0);
            len   = quiet ? int'($urandom_range(20, 40)) : int'($urandom_range(5, 15));
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                enter    = quiet ? 1'b0 : 1'($urandom_range(0, 1));
                digit_in = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15))
                                                       : 4'($urandom_range(0, 9));
                sign_in  = 1'($urandom_range(0, 1));
                clear    = !quiet && ($urandom_range(0, 24) == 0);
                if ($urandom_range(0, 7) == 0) begin
                    result_bcd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                                  4'($urandom_range(0, 9))};
                    result_neg = 1'($urandom_range(0, 1));
                end
                rst_n = ($urandom_range(0, 399) != 0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
